load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_load_ext.sv | 23 ++
 rtl/load_store_unit.sv | 109 ++++++++++
 tb/tb_load_store_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM encoding and
// small decode/merge helpers used by the top and the load extension block.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic ST_IDLE      = 1'b0;
  localparam logic ST_RMW_WRITE = 1'b1;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = a[0];
      F3_W:        mis = (a != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Sub-word stores overwrite only the low byte/halfword of the word read back.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3);
    logic [31:0] merged;
    case (f3)
      F3_B:    merged = {old_word[31:8], wdata[7:0]};
      F3_H:    merged = {old_word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational sign/zero extension of the memory word for RV32I loads.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  // Select and extend the addressed low byte/halfword.
  always_comb begin
    data = 32'h0000_0000;
    case (funct3)
      F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   data = {24'h00_0000, rdata[7:0]};
      F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   data = {16'h0000, rdata[15:0]};
      F3_W:    data = rdata;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-cycle loads and SW, read-modify-write SB/SH.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/HU/SH/W/SW into faults.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_exc
);

  logic        state_r;
  logic [31:0] addr_r;
  logic [31:0] merge_r;
  logic        accept_s;
  logic        fault_s;
  logic        mem_we_s;
  logic [31:0] ld_data_s;

  assign req_ready = (state_r == ST_IDLE);
  assign accept_s  = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault_s = f3_illegal(req_is_store, req_funct3) ||
                   f3_misaligned(req_funct3, req_addr[1:0]);
`else
  assign fault_s = f3_illegal(req_is_store, req_funct3);
`endif

  lsu_load_ext u_load_ext (
    .funct3 (req_funct3),
    .rdata  (mem_rdata),
    .data   (ld_data_s)
  );

  // Memory port steering: pass-through in IDLE, latched merge in RMW_WRITE.
  always_comb begin
    mem_we_s  = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if (state_r == ST_RMW_WRITE) begin
      mem_we_s  = 1'b1;
      mem_addr  = addr_r;
      mem_wdata = merge_r;
    end else begin
      mem_we_s = accept_s && req_is_store && !fault_s && (req_funct3 == F3_W);
    end
  end

  // Reset must silence the write strobe immediately, even mid-RMW.
  assign mem_we = mem_we_s && rst_n;

  // FSM and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      addr_r    <= 32'h0000_0000;
      merge_r   <= 32'h0000_0000;
      rsp_valid <= 1'b0;
      rsp_rd    <= 5'd0;
      rsp_data  <= 32'h0000_0000;
      rsp_exc   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rd    <= 5'd0;
      rsp_data  <= 32'h0000_0000;
      rsp_exc   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!accept_s) begin
            state_r <= ST_IDLE;
          end else if (fault_s) begin
            rsp_valid <= 1'b1;
            rsp_exc   <= 1'b1;
          end else if (!req_is_store) begin
            rsp_valid <= 1'b1;
            rsp_rd    <= req_rd;
            rsp_data  <= ld_data_s;
          end else if (req_funct3 == F3_W) begin
            rsp_valid <= 1'b1;
          end else begin
            state_r <= ST_RMW_WRITE;
            addr_r  <= req_addr;
            merge_r <= store_merge(mem_rdata, req_wdata, req_funct3);
          end
        end
        ST_RMW_WRITE: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 1'b1;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_exc;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:1023];
  logic [9:0]  a0, a1, a2, a3;
  logic        acc_we, acc_ready;
  logic [31:0] acc_wdata, acc_addr;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_exc(rsp_exc)
  );

  always #5 clk = ~clk;

  assign a0 = mem_addr[9:0];
  assign a1 = mem_addr[9:0] + 10'd1;
  assign a2 = mem_addr[9:0] + 10'd2;
  assign a3 = mem_addr[9:0] + 10'd3;
  assign mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[a0] <= mem_wdata[7:0];
      mem[a1] <= mem_wdata[15:8];
      mem[a2] <= mem_wdata[23:16];
      mem[a3] <= mem_wdata[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    acc_we = mem_we; acc_ready = req_ready; acc_wdata = mem_wdata; acc_addr = mem_addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]} = 32'h8000_00F0;
    {mem[10'h107], mem[10'h106], mem[10'h105], mem[10'h104]} = 32'h5566_7788;
    {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]} = 32'h1122_3344;

    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_exc", {31'd0, rsp_exc}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    issue(1'b0, 3'b000, 32'h100, 32'h0, 5'd5);
    chk("lb_we", {31'd0, acc_we}, 32'd0);
    chk("lb_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lb_data", rsp_data, 32'hFFFF_FFF0);
    chk("lb_rd", {27'd0, rsp_rd}, 32'd5);
    chk("lb_exc", {31'd0, rsp_exc}, 32'd0);
    tick();
    chk("lb_pulse", {31'd0, rsp_valid}, 32'd0);

    issue(1'b0, 3'b100, 32'h100, 32'h0, 5'd6);
    chk("lbu_data", rsp_data, 32'h0000_00F0);
    issue(1'b0, 3'b001, 32'h100, 32'h0, 5'd6);
    chk("lh_pos_data", rsp_data, 32'h0000_00F0);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd6);
    chk("lh_neg_data", rsp_data, 32'hFFFF_8000);
    issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd6);
    chk("lhu_data", rsp_data, 32'h0000_8000);

    issue(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 5'd7);
    chk("sw_we", {31'd0, acc_we}, 32'd1);
    chk("sw_wdata", acc_wdata, 32'hDEAD_BEEF);
    chk("sw_ready", {31'd0, acc_ready}, 32'd1);
    chk("sw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sw_rd", {27'd0, rsp_rd}, 32'd0);
    chk("sw_data", rsp_data, 32'h0);
    chk("sw_ready_after", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h200, 32'h0, 5'd8);
    chk("lw_sw_ready", {31'd0, acc_ready}, 32'd1);
    chk("lw_sw_data", rsp_data, 32'hDEAD_BEEF);

    issue(1'b1, 3'b001, 32'h300, 32'h0000_ABCD, 5'd9);
    chk("sh_acc_we", {31'd0, acc_we}, 32'd0);
    chk("sh_busy_ready", {31'd0, req_ready}, 32'd0);
    chk("sh_busy_valid", {31'd0, rsp_valid}, 32'd0);
    issue(1'b1, 3'b010, 32'h200, 32'h0, 5'd1);
    chk("rmw_we", {31'd0, acc_we}, 32'd1);
    chk("rmw_addr", acc_addr, 32'h300);
    chk("rmw_wdata", acc_wdata, 32'h1122_ABCD);
    chk("rmw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rmw_rd", {27'd0, rsp_rd}, 32'd0);
    chk("rmw_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd2);
    chk("lw_sh_data", rsp_data, 32'h1122_ABCD);
    issue(1'b0, 3'b010, 32'h200, 32'h0, 5'd2);
    chk("ignored_req", rsp_data, 32'hDEAD_BEEF);

    issue(1'b1, 3'b000, 32'h300, 32'h0000_0055, 5'd0);
    tick();
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd2);
    chk("lw_sb_data", rsp_data, 32'h1122_AB55);

    issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd9);
    chk("ill_ld_we", {31'd0, acc_we}, 32'd0);
    chk("ill_ld_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ill_ld_exc", {31'd0, rsp_exc}, 32'd1);
    chk("ill_ld_rd", {27'd0, rsp_rd}, 32'd0);
    chk("ill_ld_data", rsp_data, 32'h0);
    issue(1'b1, 3'b110, 32'h200, 32'h0, 5'd9);
    chk("ill_st_we", {31'd0, acc_we}, 32'd0);
    chk("ill_st_exc", {31'd0, rsp_exc}, 32'd1);
    tick();
    chk("ill_st_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h200, 32'h0, 5'd2);
    chk("ill_st_mem", rsp_data, 32'hDEAD_BEEF);

    issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd3);
    chk("mis_we", {31'd0, acc_we}, 32'd0);
    chk("mis_valid", {31'd0, rsp_valid}, 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_exc", {31'd0, rsp_exc}, 32'd1);
    chk("mis_data", rsp_data, 32'h0);
    chk("mis_rd", {27'd0, rsp_rd}, 32'd0);
`else
    chk("mis_exc", {31'd0, rsp_exc}, 32'd0);
    chk("mis_data", rsp_data, 32'h7788_8000);
    chk("mis_rd", {27'd0, rsp_rd}, 32'd3);
`endif

    issue(1'b1, 3'b001, 32'h300, 32'h0000_1234, 5'd0);
    chk("rst_rmw_busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rmw_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rmw_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("rel_valid", {31'd0, rsp_valid}, 32'd0);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd2);
    chk("rst_rmw_mem", rsp_data, 32'h1122_AB55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
